// File: rtl/riscv_pkg.sv
// riscv_pkg: shared CDB arbiter defaults and completion payload types
package riscv_pkg;
    localparam int DefNumFus = 7;
    localparam int DefNumCdb = 2;
    typedef struct packed {
        logic [6:0]  tag;
        logic [63:0] value;
        logic        exc_v;
        logic [8:0]  exc_code;
    } fu_complete_t;
    typedef fu_complete_t cdb_broadcast_t;
    localparam int PayloadW = $bits(fu_complete_t);
    typedef logic [$clog2(DefNumFus)-1:0] cdb_src_t;
endpackage

// File: rtl/cdb_rr_multi_pick.sv
// cdb_rr_multi_pick: combinational rotating picker granting up to i_slots of N requests
module cdb_rr_multi_pick #(
    parameter int N = 7,
    parameter int K = 2,
    localparam int IW = $clog2(N),
    localparam int CW = $clog2(K + 1)
) (
    input  logic [N-1:0]    i_req,
    input  logic [IW-1:0]   i_ptr,
    input  logic [CW-1:0]   i_slots,
    output logic [K*IW-1:0] o_idx,
    output logic [CW-1:0]   o_cnt,
    output logic [IW-1:0]   o_next_ptr
);
    always_comb begin
        int cnt;
        logic [IW-1:0] j;
        cnt = 0;
        j = '0;
        o_idx = '0;
        o_next_ptr = i_ptr;
        for (int k = 0; k < N; k++) begin
            j = IW'((int'(i_ptr) + k) % N);
            if (i_req[j] && cnt < int'(i_slots)) begin
                o_idx[cnt*IW +: IW] = j;
                o_next_ptr = (int'(j) == N - 1) ? '0 : j + 1'b1;
                cnt++;
            end
        end
        o_cnt = CW'(cnt);
    end
endmodule

// File: rtl/cdb_arbiter_mp.sv
// cdb_arbiter_mp: buffered multi-port CDB arbiter (starve > priority > round-robin)
module cdb_arbiter_mp
    import riscv_pkg::*;
#(
    parameter int                 NumFus      = DefNumFus,
    parameter int                 NumCdb      = DefNumCdb,
    parameter int                 PayloadW    = riscv_pkg::PayloadW,
    parameter logic [NumFus-1:0]  PrioMask    = NumFus'(1),
    parameter int                 StarveLimit = 8,
    localparam int IW = $clog2(NumFus),
    localparam int CW = $clog2(NumCdb + 1),
    localparam int AW = $clog2(StarveLimit + 1)
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_flush,
    input  logic [NumFus-1:0]          i_fu_valid,
    input  logic [NumFus*PayloadW-1:0] i_fu_data,
    output logic [NumFus-1:0]          o_fu_ready,
    output logic [NumCdb-1:0]          o_cdb_valid,
    output logic [NumCdb*PayloadW-1:0] o_cdb_data,
    output logic [NumCdb*IW-1:0]       o_cdb_src,
    output logic [NumFus-1:0]          o_grant
);
    logic [NumFus-1:0]   r_buf_v;
    logic [PayloadW-1:0] r_buf_d [NumFus];
    logic [AW-1:0]       r_age [NumFus];
    logic [IW-1:0]       r_ptr;
    logic [NumFus-1:0]   w_taken, w_gnt;
    logic [NumCdb*IW-1:0] w_pre_idx, w_rr_idx, w_idx;
    logic [CW-1:0]       w_pre_cnt, w_rr_cnt, w_cnt;
    logic [IW-1:0]       w_next_ptr;

    always_comb begin
        int cnt;
        cnt = 0;
        w_taken = '0;
        w_pre_idx = '0;
        for (int i = 0; i < NumFus; i++)
            if (!i_flush && r_buf_v[i] && r_age[i] == AW'(StarveLimit) && cnt < NumCdb) begin
                w_taken[i] = 1'b1;
                w_pre_idx[cnt*IW +: IW] = IW'(i);
                cnt++;
            end
        for (int i = 0; i < NumFus; i++)
            if (!i_flush && r_buf_v[i] && PrioMask[i] && !w_taken[i] && cnt < NumCdb) begin
                w_taken[i] = 1'b1;
                w_pre_idx[cnt*IW +: IW] = IW'(i);
                cnt++;
            end
        w_pre_cnt = CW'(cnt);
    end

    cdb_rr_multi_pick #(.N(NumFus), .K(NumCdb)) u_rr (
        .i_req      (r_buf_v & ~w_taken & {NumFus{!i_flush}}),
        .i_ptr      (r_ptr),
        .i_slots    (CW'(NumCdb) - w_pre_cnt),
        .o_idx      (w_rr_idx),
        .o_cnt      (w_rr_cnt),
        .o_next_ptr (w_next_ptr)
    );

    // RR grantees fill the ports left over after the starve and priority stages
    always_comb begin
        w_idx = w_pre_idx;
        w_gnt = w_taken;
        for (int k = 0; k < NumCdb; k++)
            if (k < int'(w_rr_cnt)) begin
                w_idx[(int'(w_pre_cnt) + k)*IW +: IW] = w_rr_idx[k*IW +: IW];
                w_gnt[w_rr_idx[k*IW +: IW]] = 1'b1;
            end
        w_cnt = w_pre_cnt + w_rr_cnt;
    end

    assign o_fu_ready = {NumFus{!i_flush}} & (~r_buf_v | w_gnt);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_buf_v <= '0;
            r_ptr <= '0;
            o_cdb_valid <= '0;
            o_cdb_data <= '0;
            o_cdb_src <= '0;
            o_grant <= '0;
            for (int i = 0; i < NumFus; i++) r_age[i] <= '0;
        end else if (i_flush) begin
            r_buf_v <= '0;
            o_cdb_valid <= '0;
            o_grant <= '0;
            for (int i = 0; i < NumFus; i++) r_age[i] <= '0;
        end else begin
            for (int i = 0; i < NumFus; i++) begin
                if (i_fu_valid[i] && o_fu_ready[i]) begin
                    r_buf_v[i] <= 1'b1;
                    r_buf_d[i] <= i_fu_data[i*PayloadW +: PayloadW];
                end else if (w_gnt[i]) begin
                    r_buf_v[i] <= 1'b0;
                end
                r_age[i] <= (!r_buf_v[i] || w_gnt[i]) ? '0 :
                            (r_age[i] == AW'(StarveLimit)) ? r_age[i] : r_age[i] + 1'b1;
            end
            for (int p = 0; p < NumCdb; p++) begin
                o_cdb_valid[p] <= p < int'(w_cnt);
                o_cdb_data[p*PayloadW +: PayloadW] <= (p < int'(w_cnt)) ? r_buf_d[w_idx[p*IW +: IW]] : '0;
                o_cdb_src[p*IW +: IW] <= (p < int'(w_cnt)) ? w_idx[p*IW +: IW] : '0;
            end
            o_grant <= w_gnt;
            r_ptr <= w_next_ptr;
        end
    end
endmodule

// File: tb/tb_cdb_arbiter_mp.sv
// tb_cdb_arbiter_mp: directed and random checks of cdb_arbiter_mp against a queue-based model
module tb_cdb_arbiter_mp;
    localparam int NF = 7, NC = 2, PW = 81, SL = 8, IW = 3;
    localparam logic [NF-1:0] PM = 7'b0000001;

    logic clk, rst, flush;
    logic [NF-1:0] fu_valid, fu_rdy, gr, s_valid, s_rdy, s_gr;
    logic [NF*PW-1:0] fu_data, s_data;
    logic [NC-1:0] cv;
    logic [NC*PW-1:0] cd;
    logic [NC*IW-1:0] cs;
    logic [0:0] s_cv;
    logic [PW-1:0] s_cd;
    logic [IW-1:0] s_cs;

    cdb_arbiter_mp #(.NumFus(NF), .NumCdb(NC), .PayloadW(PW), .PrioMask(PM), .StarveLimit(SL)) dut (
        .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_fu_valid(fu_valid), .i_fu_data(fu_data),
        .o_fu_ready(fu_rdy), .o_cdb_valid(cv), .o_cdb_data(cd), .o_cdb_src(cs), .o_grant(gr));

    cdb_arbiter_mp #(.NumFus(NF), .NumCdb(1), .PayloadW(PW), .PrioMask(PM), .StarveLimit(3)) dut_s (
        .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_fu_valid(s_valid), .i_fu_data(s_data),
        .o_fu_ready(s_rdy), .o_cdb_valid(s_cv), .o_cdb_data(s_cd), .o_cdb_src(s_cs), .o_grant(s_gr));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0, checks = 0;
    logic          mb_v [NF];
    logic [PW-1:0] mb_d [NF];
    int            mage [NF];
    int            mptr, m_nptr;
    int            mg [$];
    logic [NF-1:0] m_rdy, m_gr;
    logic [NC-1:0] m_cv;
    logic [PW-1:0] m_cd [NC];
    int            m_cs [NC];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [PW-1:0] rnd();
        logic [95:0] t;
        t = {$urandom, $urandom, $urandom};
        return t[PW-1:0];
    endfunction

    function automatic bit inq(int j);
        foreach (mg[k]) if (mg[k] == j) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NF; i++) begin mb_v[i] = 1'b0; mage[i] = 0; end
        mptr = 0;
        m_cv = '0;
        m_gr = '0;
        for (int p = 0; p < NC; p++) begin m_cd[p] = '0; m_cs[p] = 0; end
    endtask

    task automatic compute();
        int last;
        bit any;
        mg.delete();
        last = 0;
        any = 1'b0;
        if (!flush) begin
            for (int i = 0; i < NF; i++) if (mb_v[i] && mage[i] == SL && mg.size() < NC) mg.push_back(i);
            for (int i = 0; i < NF; i++) if (mb_v[i] && PM[i] && !inq(i) && mg.size() < NC) mg.push_back(i);
            for (int k = 0; k < NF; k++) begin
                int j;
                j = (mptr + k) % NF;
                if (mb_v[j] && !inq(j) && mg.size() < NC) begin mg.push_back(j); last = j; any = 1'b1; end
            end
        end
        m_nptr = any ? (last + 1) % NF : mptr;
        for (int i = 0; i < NF; i++) m_rdy[i] = !flush && (!mb_v[i] || inq(i));
    endtask

    task automatic tick();
        #1;
        compute();
        chk("fu_ready", 128'(fu_rdy), 128'(m_rdy));
        if (rst) model_reset();
        else if (flush) begin
            for (int i = 0; i < NF; i++) begin mb_v[i] = 1'b0; mage[i] = 0; end
            m_cv = '0;
            m_gr = '0;
        end else begin
            m_cv = '0;
            m_gr = '0;
            foreach (mg[p]) begin m_cv[p] = 1'b1; m_cd[p] = mb_d[mg[p]]; m_cs[p] = mg[p]; m_gr[mg[p]] = 1'b1; end
            for (int i = 0; i < NF; i++) begin
                if (!mb_v[i] || m_gr[i]) mage[i] = 0;
                else if (mage[i] < SL) mage[i]++;
                if (fu_valid[i] && m_rdy[i]) begin mb_v[i] = 1'b1; mb_d[i] = fu_data[i*PW +: PW]; end
                else if (m_gr[i]) mb_v[i] = 1'b0;
            end
            mptr = m_nptr;
        end
        @(posedge clk);
        #1;
        chk("cdb_valid", 128'(cv), 128'(m_cv));
        chk("grant", 128'(gr), 128'(m_gr));
        for (int p = 0; p < NC; p++)
            if (m_cv[p]) begin
                chk("cdb_data", 128'(cd[p*PW +: PW]), 128'(m_cd[p]));
                chk("cdb_src", 128'(cs[p*IW +: IW]), 128'(m_cs[p]));
            end
    endtask

    task automatic set_data();
        for (int i = 0; i < NF; i++) begin fu_data[i*PW +: PW] = rnd(); s_data[i*PW +: PW] = rnd(); end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        fu_valid = '0;
        s_valid = '0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [NF-1:0] t2_exp [5];
        int s_src [7];
        bit s_v [7];
        bit seen;
        t2_exp = '{7'b0000011, 7'b0001100, 7'b0110000, 7'b1000000, 7'b0000000};
        s_src = '{0, 0, 0, 0, 5, 0, 0};
        s_v = '{0, 1, 1, 1, 1, 1, 1};
        rst = 1'b1;
        flush = 1'b0;
        fu_valid = '0;
        s_valid = '0;
        fu_data = '0;
        s_data = '0;
        @(posedge clk);
        #1;
        model_reset();
        tick();
        rst = 1'b0;
        chk("reset_ready", 128'(fu_rdy), 128'(7'h7f));
        chk("reset_valid", 128'(cv), 128'(0));
        chk("reset_grant", 128'(gr), 128'(0));
        chk("reset_src", 128'(cs), 128'(0));

        fu_valid = 7'b0001000;
        fu_data[3*PW +: PW] = 81'hABC;
        tick();
        fu_valid = '0;
        tick();
        chk("t1_valid", 128'(cv[0]), 128'(1));
        chk("t1_src", 128'(cs[IW-1:0]), 128'(3));
        chk("t1_data", 128'(cd[PW-1:0]), 128'(81'hABC));
        chk("t1_grant", 128'(gr), 128'(7'b0001000));
        tick();

        do_reset();
        fu_valid = 7'h7f;
        set_data();
        tick();
        fu_valid = '0;
        for (int t = 0; t < 5; t++) begin
            tick();
            chk("t2_grant", 128'(gr), 128'(t2_exp[t]));
        end

        seen = 1'b0;
        for (int t = 0; t < 7; t++) begin
            fu_valid = (t == 0) ? 7'b0100011 : 7'b0000011;
            s_valid = (t == 0) ? 7'b0100001 : 7'b0000001;
            set_data();
            tick();
            if ((cv[0] && cs[IW-1:0] == 3'd5) || (cv[1] && cs[2*IW-1:IW] == 3'd5)) seen = 1'b1;
            chk("t3_starve_valid", 128'(s_cv), 128'(s_v[t]));
            if (s_v[t]) chk("t3_starve_src", 128'(s_cs), 128'(s_src[t]));
        end
        chk("t3_fu5_seen", 128'(seen), 128'(1));
        fu_valid = '0;
        s_valid = '0;
        repeat (3) tick();

        for (int t = 0; t < 6; t++) begin
            fu_valid = 7'b0000100;
            set_data();
            tick();
            chk("t4_ready2", 128'(fu_rdy[2]), 128'(1));
        end
        fu_valid = '0;
        repeat (3) tick();

        fu_valid = 7'b0010010;
        set_data();
        tick();
        fu_valid = '0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t5_flush_valid", 128'(cv), 128'(0));
        repeat (2) tick();
        fu_valid = 7'b1000100;
        set_data();
        tick();
        fu_valid = '0;
        repeat (2) tick();

        fu_valid = 7'b0101010;
        set_data();
        tick();
        do_reset();
        chk("t6_rst_valid", 128'(cv), 128'(0));
        chk("t6_rst_grant", 128'(gr), 128'(0));
        fu_valid = 7'b1000001;
        set_data();
        tick();
        fu_valid = '0;
        tick();
        chk("t6_valid", 128'(cv), 128'(2'b11));
        chk("t6_src0", 128'(cs[IW-1:0]), 128'(0));
        chk("t6_src1", 128'(cs[2*IW-1:IW]), 128'(6));

        for (int t = 0; t < 400; t++) begin
            fu_valid = 7'($urandom);
            flush = ($urandom % 24) == 0;
            rst = ($urandom % 97) == 0;
            set_data();
            tick();
        end
        rst = 1'b0;
        flush = 1'b0;
        fu_valid = '0;
        repeat (4) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
